// File: rtl/vending_pkg.sv
// Shared types and constants for the vending-machine transaction controller.
package vending_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ACUM    = 3'd1,
        ST_LIBERA  = 3'd2,
        ST_DEVOLVE = 3'd3,
        ST_ESPERA  = 3'd4
    } state_t;

    localparam int unsigned V25  = 25;
    localparam int unsigned V50  = 50;
    localparam int unsigned V100 = 100;

    localparam int unsigned PRECO_DEF    = 150;
    localparam int unsigned MAX_CRED_DEF = 250;
    localparam int unsigned CRED_W_DEF   = 8;

endpackage

// File: rtl/soma_moedas.sv
// Combinational value of the coins presented in the current cycle (simultaneous coins summed).
module soma_moedas
    import vending_pkg::*;
#(
    parameter int unsigned CRED_W = CRED_W_DEF
) (
    input  logic              m25_i,
    input  logic              m50_i,
    input  logic              m100_i,
    output logic [CRED_W:0]   valor_c_o
);

    localparam int unsigned SUM_W = CRED_W + 1;

    assign valor_c_o = (m25_i  ? SUM_W'(V25)  : '0)
                     + (m50_i  ? SUM_W'(V50)  : '0)
                     + (m100_i ? SUM_W'(V100) : '0);

endmodule

// File: rtl/ctrl_venda.sv
// Vending transaction controller: accumulates credit, releases product or refunds,
// and closes each LP/DM action through the FIM handshake returned by reg_fim.
module ctrl_venda
    import vending_pkg::*;
#(
    parameter int unsigned PRECO    = PRECO_DEF,
    parameter int unsigned MAX_CRED = MAX_CRED_DEF,
    parameter int unsigned CRED_W   = CRED_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              M25,
    input  logic              M50,
    input  logic              M100,
    input  logic              CANCEL,
    input  logic              FIM,
    output logic              LP,
    output logic              DM,
    output logic [CRED_W-1:0] CREDITO,
    output logic [CRED_W-1:0] TROCO,
    output logic              REJEITA,
    output logic              OCUPADO
);

    localparam int unsigned SUM_W = CRED_W + 1;
    localparam logic [SUM_W-1:0] PRECO_S = SUM_W'(PRECO);
    localparam logic [SUM_W-1:0] MAX_S   = SUM_W'(MAX_CRED);

    state_t              state_q, state_d;
    logic [CRED_W-1:0]   credito_q, credito_d;
    logic [CRED_W-1:0]   troco_q, troco_d;
    logic                lp_q, lp_d;
    logic                dm_q, dm_d;
    logic                rej_q, rej_d;
    logic                ocup_q, ocup_d;
    logic                pend_q, pend_d;

    logic [SUM_W-1:0]    v_c;
    logic [SUM_W-1:0]    soma_c;
    logic                coin_c;

    soma_moedas #(
        .CRED_W (CRED_W)
    ) u_soma (
        .m25_i     (M25),
        .m50_i     (M50),
        .m100_i    (M100),
        .valor_c_o (v_c)
    );

    assign soma_c = {1'b0, credito_q} + v_c;
    assign coin_c = (v_c != '0);

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            credito_q <= '0;
            troco_q   <= '0;
            lp_q      <= 1'b0;
            dm_q      <= 1'b0;
            rej_q     <= 1'b0;
            ocup_q    <= 1'b0;
            pend_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            credito_q <= credito_d;
            troco_q   <= troco_d;
            lp_q      <= lp_d;
            dm_q      <= dm_d;
            rej_q     <= rej_d;
            ocup_q    <= ocup_d;
            pend_q    <= pend_d;
        end
    end

    // Next-state and next-output decode
    always_comb begin
        state_d   = state_q;
        credito_d = credito_q;
        troco_d   = troco_q;
        lp_d      = lp_q;
        dm_d      = dm_q;
        rej_d     = 1'b0;
        pend_d    = pend_q;

        case (state_q)
            ST_IDLE, ST_ACUM: begin
                if (CANCEL && (soma_c != '0)) begin
                    // Cancel beats a price-reaching coin; an overflowing coin is refused, not refunded twice
                    if (soma_c <= MAX_S) begin
                        troco_d = CRED_W'(soma_c);
                    end else begin
                        troco_d = credito_q;
                        rej_d   = 1'b1;
                    end
                    credito_d = '0;
                    dm_d      = 1'b1;
                    pend_d    = 1'b0;
                    state_d   = ST_DEVOLVE;
                end else if (coin_c) begin
                    if (soma_c > MAX_S) begin
                        rej_d = 1'b1;
                    end else if (soma_c >= PRECO_S) begin
                        troco_d   = CRED_W'(soma_c - PRECO_S);
                        pend_d    = (soma_c != PRECO_S);
                        credito_d = '0;
                        lp_d      = 1'b1;
                        state_d   = ST_LIBERA;
                    end else begin
                        credito_d = CRED_W'(soma_c);
                        state_d   = ST_ACUM;
                    end
                end
            end
            ST_LIBERA: begin
                rej_d = coin_c;
                if (FIM) begin
                    lp_d    = 1'b0;
                    state_d = ST_ESPERA;
                end
            end
            ST_DEVOLVE: begin
                rej_d = coin_c;
                if (FIM) begin
                    dm_d    = 1'b0;
                    pend_d  = 1'b0;
                    state_d = ST_ESPERA;
                end
            end
            ST_ESPERA: begin
                // Wait for reg_fim to drain before starting the change refund or going idle
                rej_d = coin_c;
                if (!FIM) begin
                    if (pend_q) begin
                        dm_d    = 1'b1;
                        state_d = ST_DEVOLVE;
                    end else begin
                        troco_d = '0;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        ocup_d = (state_d == ST_LIBERA) || (state_d == ST_DEVOLVE) || (state_d == ST_ESPERA);
    end

    assign LP      = lp_q;
    assign DM      = dm_q;
    assign CREDITO = credito_q;
    assign TROCO   = troco_q;
    assign REJEITA = rej_q;
    assign OCUPADO = ocup_q;

endmodule

// File: doc/ctrl_venda.md
Name: ctrl_venda

Overview:
Vending-machine transaction controller. It accumulates coin credit, decides between product release and refund, and drives LP (liberar produto) and DM (devolver moeda). It is the initiating end of the LP/DM -> FIM handshake: reg_fim delays LP|DM by 4 clocks and returns FIM, which ctrl_venda uses to close each dispense or refund. It runs on the same divided clock as reg_fim.

Parameters:
PRECO, 150, product price in centavos; multiple of 25, range 25..MAX_CRED.
MAX_CRED, 250, maximum credit held in centavos; coins that would exceed it are rejected.
CRED_W, 8, width of CREDITO/TROCO; must satisfy 2^CRED_W > MAX_CRED.

Ports:
clk  input  1  system clock (divided, 1 s).
rst_n  input  1  asynchronous active-low reset.
M25  input  1  25-centavo coin pulse; one cycle, synchronous, already debounced.
M50  input  1  50-centavo coin pulse.
M100  input  1  100-centavo coin pulse.
CANCEL  input  1  user cancel request (level, sampled each cycle).
FIM  input  1  end-of-action acknowledge from reg_fim.
LP  output  1  release product; registered.
DM  output  1  return coins/change; registered.
CREDITO  output  CRED_W  current accumulated credit.
TROCO  output  CRED_W  amount being or to be refunded.
REJEITA  output  1  one-cycle pulse: coin(s) this cycle refused.
OCUPADO  output  1  high in LIBERA/DEVOLVE/ESPERA.

Behaviour:
- Reset (async, rst_n=0): state IDLE; LP=DM=REJEITA=OCUPADO=0; CREDITO=TROCO=0. Mid-transaction reset drops LP/DM immediately and loses credit (accepted).
- Coin value per cycle v = 25*M25 + 50*M50 + 100*M100 (simultaneous coins summed; max 175). Sum computed at CRED_W+1 bits.
- States: IDLE, ACUM, LIBERA, DEVOLVE, ESPERA. All outputs are registered and update on the clock edge that enters a state.
- IDLE/ACUM, evaluated in priority order:
  - CANCEL=1 and (CREDITO+v)>0:
    - if CREDITO+v <= MAX_CRED, TROCO<=CREDITO+v; otherwise TROCO<=CREDITO and REJEITA pulses.
    - CREDITO<=0, DM<=1, go DEVOLVE. Cancel wins over a simultaneous price-reaching coin.
  - CANCEL=1 in IDLE with v=0: ignored.
  - v>0 and CREDITO+v > MAX_CRED: REJEITA<=1 for one cycle; CREDITO unchanged; state unchanged.
  - v>0 and CREDITO+v >= PRECO: TROCO<=CREDITO+v-PRECO, CREDITO<=0, LP<=1, go LIBERA.
  - v>0 otherwise: CREDITO<=CREDITO+v, go/stay ACUM.
- LIBERA: hold LP=1 until FIM=1 is sampled, then LP<=0 and go ESPERA.
- DEVOLVE: hold DM=1 until FIM=1 is sampled, then DM<=0, clear the change-pending flag, and go ESPERA.
- ESPERA: wait for FIM=0 sampled (reg_fim pipeline drained).
  - If change is pending (TROCO>0 after LIBERA), DM<=1 and go DEVOLVE.
  - Otherwise TROCO<=0 and go IDLE.
- In LIBERA/DEVOLVE/ESPERA every coin pulse produces REJEITA (coin physically returned); CANCEL is ignored.
- LP and DM are never high in the same cycle. FIM=1 seen in IDLE/ACUM is ignored.
- Handshake latency with reg_fim:
  - LP rises after edge k.
  - FIM rises after edge k+4; sampled at k+5, where LP falls.
  - FIM falls after k+9; sampled at k+10, leaving ESPERA.

Decomposition:
- Package vending_pkg holds:
  - state encoding enum;
  - coin value constants V25=25, V50=50, V100=100;
  - default PRECO/MAX_CRED.
- One natural sub-module, soma_moedas: combinational M25/M50/M100 -> CRED_W+1-bit value v. It is reused by the display logic.

Test Plan:
- rst_n=0 mid-run -> LP=DM=0, CREDITO=TROCO=0, OCUPADO=0 with no clock edge.
- M100, M50 (reg_fim in loop), covering LIBERA -> ESPERA -> IDLE:
  - CREDITO=100 after the first coin;
  - after M50: LP=1, CREDITO=0, TROCO=0;
  - LP high exactly 5 cycles; IDLE 10 cycles after LP rise; DM never asserted.
- M100, M100:
  - LP=1 with TROCO=50;
  - after the LP handshake and FIM low: DM=1 with TROCO=50 for 5 cycles;
  - then IDLE with TROCO=0.
- M50, then CANCEL=1 -> DM=1, TROCO=50, CREDITO=0; LP never asserts; returns to IDLE after the handshake.
- Saturation:
  - M100 then M25 -> CREDITO=125;
  - M25+M50+M100 in one cycle (300>250) -> REJEITA one cycle, CREDITO stays 125.
- M25 pulse during LIBERA -> REJEITA=1 for one cycle; CREDITO stays 0; TROCO unchanged.
